mult_share_sched: RTL and testbench
===================================

// Module: mult_share_sched
// PURPOSE
//  Scheduler that shares one 4x4 shift-add multiplier core (START/READY handshake, 8-bit product P7..P0)
//  among NREQ requesters. Arbitrates round-robin, sequences START/operand load, waits for READY,
//  captures the product and returns it to the granted requester. Sits between client FSMs and the core.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  TIMEOUT  15  max cycles in WAIT before abort with error (1..2**TW-1)
//  TW       4   width of watchdog counter
// PORTS
//  CK         in   1        clock, all state updates on rising edge
//  RSTN       in   1        synchronous active-low reset, sampled on CK rising edge
//  req_valid  in   NREQ     request i pending
//  req_a      in   4*NREQ   operand A of requester i at [4i+3:4i]
//  req_b      in   4*NREQ   operand B of requester i at [4i+3:4i]
//  req_ready  out  NREQ     one-hot; request i accepted when req_valid[i]&req_ready[i]
//  rsp_valid  out  NREQ     one-hot; response for requester i present
//  rsp_ready  in   NREQ     requester i consumes response
//  rsp_data   out  8        product A*B (unsigned); 0 on error
//  rsp_err    out  1        watchdog abort flag, qualified by |rsp_valid
//  busy       out  1        high in every state except IDLE
//  MUL_START  out  1        start pulse to multiplier core
//  MUL_A      out  4        operand A to core
//  MUL_B      out  4        operand B to core
//  MUL_READY  in   1        core done / idle
//  MUL_P      in   8        core product {P7..P0}
// BEHAVIOUR
//  Reset (RSTN=0 at edge): state=INIT, MUL_START=0, MUL_A=MUL_B=0, req_ready=0, rsp_valid=0,
//   rsp_data=0, rsp_err=0, busy=1, rr pointer=0, watchdog=0. Reset mid-operation aborts without response.
//  INIT: MUL_START=1 one cycle (flush core), then -> INIT_WAIT; INIT_WAIT holds until MUL_READY=1
//   -> IDLE (no watchdog in INIT_WAIT; blind first cycle as in BLIND).
//  IDLE: busy=0. Grant = first i with req_valid[i] at or after rr pointer (wrap NREQ-1 -> 0).
//   req_ready driven combinationally one-hot for grant; on accept latch a,b,index -> SETUP, rr=index+1 mod NREQ.
//  SETUP (1 cycle): MUL_A/MUL_B = latched operands, MUL_START=0 (core loads B while READY high) -> LAUNCH.
//  LAUNCH (1 cycle): MUL_START=1, operands held -> BLIND; watchdog cleared.
//  BLIND (1 cycle): MUL_READY ignored (stale from prior op) -> WAIT.
//  WAIT: watchdog++ each cycle; MUL_READY=1 -> capture MUL_P into rsp_data, rsp_err=0 -> DONE;
//   watchdog reaches TIMEOUT with MUL_READY=0 -> rsp_data=0, rsp_err=1 -> DONE. READY wins if same cycle.
//  DONE: rsp_valid[index]=1, rsp_data/rsp_err stable until rsp_ready[index]=1 -> IDLE (rsp_valid drops next cycle).
//   rsp_ready of non-granted requesters ignored. After an error, next grant goes via INIT (re-flush core).
//  MUL_A/MUL_B held stable from SETUP through exit of WAIT; MUL_START high only in INIT/LAUNCH.
//  Throughput: accept->rsp_valid = 3 + core latency cycles; back-to-back accept one cycle after rsp handshake.
//  Requests arriving while busy wait; req_valid must stay high until accepted (no drop, no reorder per requester).
// TESTING
//  1. Reset release, core model READY after 6 cycles -> busy=1 until INIT_WAIT sees READY, then busy=0.
//  2. req0 a=7 b=9 -> one MUL_START pulse 2 cycles after accept, rsp_valid=4'b0001, rsp_data=8'h3F, rsp_err=0.
//  3. a=15 b=15 on req3 -> rsp_data=8'hE1; a=0 b=15 -> 8'h00, rsp_err=0.
//  4. All 4 req_valid held high, 8 ops -> grant order 0,1,2,3,0,1,2,3; each rsp to matching one-hot bit.
//  5. MUL_READY stuck 0 -> rsp_err=1, rsp_data=0 exactly TIMEOUT cycles after entering WAIT; next op runs INIT first.
//  6. rsp_ready held 0 for 10 cycles in DONE -> data stable, no new grant; RSTN=0 during WAIT -> all outputs reset values.

Source files
------------

// File: rtl/mult_share_sched.sv
// mult_share_sched: round-robin scheduler sharing one 4x4 shift-add multiplier
// core among NREQ requesters. Handles core flush, START/READY sequencing,
// a watchdog on the core, and a one-hot response handshake per requester.
module mult_share_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned TW      = 4
) (
    input  logic                CK,
    input  logic                RSTN,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [4*NREQ-1:0]   req_a,
    input  logic [4*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [7:0]          rsp_data,
    output logic                rsp_err,
    output logic                busy,
    output logic                MUL_START,
    output logic [3:0]          MUL_A,
    output logic [3:0]          MUL_B,
    input  logic                MUL_READY,
    input  logic [7:0]          MUL_P
);

    localparam int unsigned IW  = $clog2(NREQ);
    localparam int unsigned IW1 = IW + 1;

    localparam logic [2:0] S_INIT      = 3'd0;
    localparam logic [2:0] S_INIT_WAIT = 3'd1;
    localparam logic [2:0] S_IDLE      = 3'd2;
    localparam logic [2:0] S_SETUP     = 3'd3;
    localparam logic [2:0] S_LAUNCH    = 3'd4;
    localparam logic [2:0] S_BLIND     = 3'd5;
    localparam logic [2:0] S_WAIT      = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    logic [2:0]      state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [TW-1:0]   wd_q, wd_d;
    logic            blind_q, blind_d;

    logic            start_d;
    logic [3:0]      mul_a_d, mul_b_d;
    logic [NREQ-1:0] rsp_valid_d;
    logic [7:0]      rsp_data_d;
    logic            rsp_err_d;
    logic            busy_d;

    logic            gnt_found;
    logic [IW-1:0]   gnt_idx;
    logic [NREQ-1:0] gnt_onehot;
    logic [3:0]      a_sel, b_sel;
    logic            accept;

    // Round-robin search: first pending requester at or after the rr pointer
    always_comb begin
        logic [IW1-1:0] cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_q} + IW1'(i);
            if (cand >= IW1'(NREQ)) begin
                cand = cand - IW1'(NREQ);
            end
            if (!gnt_found && req_valid[cand[IW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IW-1:0];
            end
        end
    end

    // Operand mux for the granted requester
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IW'(i)) begin
                a_sel = req_a[4*i +: 4];
                b_sel = req_b[4*i +: 4];
            end
        end
    end

    assign gnt_onehot = NREQ'(1) << gnt_idx;
    assign accept     = (state_q == S_IDLE) && gnt_found;
    assign req_ready  = accept ? gnt_onehot : '0;

    // Next-state and next-output decode
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rr_d        = rr_q;
        wd_d        = wd_q;
        blind_d     = 1'b0;
        start_d     = 1'b0;
        mul_a_d     = MUL_A;
        mul_b_d     = MUL_B;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;
        rsp_err_d   = rsp_err;

        case (state_q)
            S_INIT: begin
                // flush pulse lands in the first INIT_WAIT cycle
                start_d = 1'b1;
                state_d = S_INIT_WAIT;
            end
            S_INIT_WAIT: begin
                // READY is stale while the flush pulse is out and one cycle after
                blind_d = MUL_START;
                if (!MUL_START && !blind_q && MUL_READY) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (accept) begin
                    idx_d   = gnt_idx;
                    rr_d    = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
                    mul_a_d = a_sel;
                    mul_b_d = b_sel;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                start_d = 1'b1;
                state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                wd_d    = '0;
                state_d = S_BLIND;
            end
            S_BLIND: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_q + TW'(1);
                if (MUL_READY) begin
                    rsp_data_d  = MUL_P;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = NREQ'(1) << idx_q;
                    state_d     = S_DONE;
                end else if (wd_q == TW'(TIMEOUT - 1)) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = NREQ'(1) << idx_q;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready[idx_q]) begin
                    rsp_valid_d = '0;
                    // a timed-out core is re-flushed before the next grant
                    state_d     = rsp_err ? S_INIT : S_IDLE;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge CK) begin
        if (!RSTN) begin
            state_q   <= S_INIT;
            idx_q     <= '0;
            rr_q      <= '0;
            wd_q      <= '0;
            blind_q   <= 1'b0;
            MUL_START <= 1'b0;
            MUL_A     <= '0;
            MUL_B     <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rr_q      <= rr_d;
            wd_q      <= wd_d;
            blind_q   <= blind_d;
            MUL_START <= start_d;
            MUL_A     <= mul_a_d;
            MUL_B     <= mul_b_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            rsp_err   <= rsp_err_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_mult_share_sched.sv
// Bench for mult_share_sched with a behavioural shift-add core model and a
// response scoreboard.
module tb_mult_share_sched;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 15;
    localparam int TW      = 4;
    localparam int LAT     = 4;

    logic              CK = 1'b0;
    logic              RSTN;
    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [7:0]        rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              MUL_START;
    logic [3:0]        MUL_A;
    logic [3:0]        MUL_B;
    logic              MUL_READY;
    logic [7:0]        MUL_P;

    typedef struct packed {
        logic [3:0] onehot;
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mult_share_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .CK        (CK),
        .RSTN      (RSTN),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .MUL_START (MUL_START),
        .MUL_A     (MUL_A),
        .MUL_B     (MUL_B),
        .MUL_READY (MUL_READY),
        .MUL_P     (MUL_P)
    );

    always #5 CK = ~CK;

    // Core model: START restarts a LAT-cycle multiply; READY high when idle/done
    logic       core_rdy;
    logic [3:0] core_a, core_b;
    int         core_cnt;
    logic       stuck;

    always @(posedge CK) begin
        if (!RSTN) begin
            core_rdy <= 1'b0;
            core_cnt <= 6;
            core_a   <= '0;
            core_b   <= '0;
            MUL_P    <= '0;
        end else if (MUL_START) begin
            core_rdy <= 1'b0;
            core_cnt <= LAT;
            core_a   <= MUL_A;
            core_b   <= MUL_B;
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                core_rdy <= 1'b1;
                MUL_P    <= {4'b0, core_a} * {4'b0, core_b};
            end
        end
    end

    assign MUL_READY = core_rdy & ~stuck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int idx, input logic [3:0] a, input logic [3:0] b, input logic err);
        exp_t e;
        e.onehot = 4'(32'(1) << idx);
        e.data   = err ? 8'h00 : ({4'b0, a} * {4'b0, b});
        e.err    = err;
        sb.push_back(e);
    endtask

    task automatic set_req(input int idx, input logic [3:0] a, input logic [3:0] b);
        req_a[4*idx +: 4] = a;
        req_b[4*idx +: 4] = b;
        req_valid[idx]    = 1'b1;
    endtask

    // Wait for a grant, check it is the expected requester, let it be accepted
    task automatic accept(input int idx);
        int n;
        n = 0;
        #1;
        while (req_ready === '0 && n < 60) begin
            @(negedge CK);
            n++;
        end
        chk("grant", 32'(req_ready), 32'(1) << idx);
        @(posedge CK);
        #1;
    endtask

    // Wait for a response, compare with the scoreboard head, handshake it
    task automatic collect();
        exp_t e;
        int   n;
        n = 0;
        #1;
        while (rsp_valid === '0 && n < 100) begin
            @(negedge CK);
            n++;
        end
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL sb_underflow observed=%0h expected=nonempty", rsp_valid);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(e.onehot));
            chk("rsp_data", 32'(rsp_data), 32'(e.data));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
        rsp_ready = rsp_valid;
        @(posedge CK);
        #1;
        rsp_ready = '0;
        @(negedge CK);
        chk("rsp_drop", 32'(rsp_valid), 32'(0));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 60) begin
            @(negedge CK);
            n++;
        end
        chk(tag, 32'(busy), 32'(0));
    endtask

    initial begin
        int n;
        int cyc;
        int ok;
        int starts;

        RSTN      = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '0;
        stuck     = 1'b0;

        // 1. reset values, then flush completes and busy drops
        repeat (3) @(posedge CK);
        @(negedge CK);
        chk("rst_busy", 32'(busy), 32'(1));
        chk("rst_start", 32'(MUL_START), 32'(0));
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        RSTN = 1'b1;
        @(negedge CK);
        chk("init_busy", 32'(busy), 32'(1));
        wait_idle("init_idle");

        // 2. req0 7*9, START pulse two cycles after accept
        set_req(0, 4'd7, 4'd9);
        push(0, 4'd7, 4'd9, 1'b0);
        accept(0);
        req_valid = '0;
        @(negedge CK);
        chk("setup_start", 32'(MUL_START), 32'(0));
        chk("setup_a", 32'(MUL_A), 32'(7));
        chk("setup_b", 32'(MUL_B), 32'(9));
        @(negedge CK);
        chk("launch_start", 32'(MUL_START), 32'(1));
        @(negedge CK);
        chk("blind_start", 32'(MUL_START), 32'(0));
        chk("blind_a", 32'(MUL_A), 32'(7));
        collect();

        // 3. operand corners; req3 last so the rr pointer wraps to 0
        set_req(0, 4'd0, 4'd15);
        push(0, 4'd0, 4'd15, 1'b0);
        accept(0);
        req_valid = '0;
        collect();
        set_req(3, 4'd15, 4'd15);
        push(3, 4'd15, 4'd15, 1'b0);
        accept(3);
        req_valid = '0;
        collect();

        // 4. all requesters pending: grants rotate 0,1,2,3,0,1,2,3
        set_req(0, 4'd3, 4'd11);
        set_req(1, 4'd5, 4'd6);
        set_req(2, 4'd9, 4'd13);
        set_req(3, 4'd14, 4'd2);
        for (int k = 0; k < 8; k++) begin
            push(k % 4, req_a[4*(k%4) +: 4], req_b[4*(k%4) +: 4], 1'b0);
            accept(k % 4);
            if (k >= 4) req_valid[k % 4] = 1'b0;
            collect();
        end

        // 5. core stuck: error exactly TIMEOUT cycles into WAIT, then re-flush
        stuck = 1'b1;
        set_req(1, 4'd3, 4'd5);
        push(1, 4'd3, 4'd5, 1'b1);
        accept(1);
        req_valid = '0;
        n = 0;
        do begin
            @(negedge CK);
            n++;
        end while (MUL_START !== 1'b1 && n < 10);
        cyc = 0;
        do begin
            @(negedge CK);
            cyc++;
        end while (rsp_valid === '0 && cyc < 40);
        chk("timeout_cycles", 32'(cyc), 32'(2 + TIMEOUT));
        collect();
        chk("err_reinit_busy", 32'(busy), 32'(1));
        stuck  = 1'b0;
        starts = 0;
        n      = 0;
        while (busy !== 1'b0 && n < 60) begin
            if (MUL_START) starts++;
            @(negedge CK);
            n++;
        end
        chk("reflush_pulses", 32'(starts), 32'(1));
        set_req(2, 4'd6, 4'd7);
        push(2, 4'd6, 4'd7, 1'b0);
        accept(2);
        req_valid = '0;
        collect();

        // 6a. response stalled 10 cycles, foreign rsp_ready ignored
        set_req(2, 4'd12, 4'd11);
        push(2, 4'd12, 4'd11, 1'b0);
        accept(2);
        req_valid = '0;
        set_req(0, 4'd1, 4'd1);
        n = 0;
        while (rsp_valid === '0 && n < 60) begin
            @(negedge CK);
            n++;
        end
        rsp_ready = 4'b0001;
        ok = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CK);
            if (rsp_valid === 4'b0100 && rsp_data === 8'h84 && rsp_err === 1'b0 && req_ready === '0)
                ok++;
        end
        chk("stall_hold", 32'(ok), 32'(10));
        rsp_ready = '0;
        collect();
        push(0, 4'd1, 4'd1, 1'b0);
        accept(0);
        req_valid = '0;
        collect();

        // 6b. reset while waiting on the core: no response, reset values
        set_req(3, 4'd5, 4'd5);
        accept(3);
        n = 0;
        do begin
            @(negedge CK);
            n++;
        end while (MUL_START !== 1'b1 && n < 10);
        @(negedge CK);
        @(negedge CK);
        @(negedge CK);
        RSTN = 1'b0;
        @(negedge CK);
        chk("wrst_start", 32'(MUL_START), 32'(0));
        chk("wrst_a", 32'(MUL_A), 32'(0));
        chk("wrst_b", 32'(MUL_B), 32'(0));
        chk("wrst_req_ready", 32'(req_ready), 32'(0));
        chk("wrst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("wrst_rsp_data", 32'(rsp_data), 32'(0));
        chk("wrst_rsp_err", 32'(rsp_err), 32'(0));
        chk("wrst_busy", 32'(busy), 32'(1));
        RSTN = 1'b1;
        @(negedge CK);
        wait_idle("wrst_idle");
        push(3, 4'd5, 4'd5, 1'b0);
        accept(3);
        req_valid = '0;
        collect();
        chk("sb_drained", 32'(sb.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
